execute_multdiv: RTL and testbench

- Parametrised iterative signed multiply/divide unit for the execute stage of the pipelined processor.
- Replaces single-cycle mul/div ALU paths, which limit Fmax, with a radix-2 shift-add multiplier and restoring divider.
- Stalls the pipeline while busy and returns result, destination tag and exception flag.
- Execute stage maps the exception flag to codes 4 (mul) and 5 (div).

---
 rtl/execute_multdiv_pkg.sv | 18 +
 rtl/execute_multdiv_if.sv | 27 ++
 rtl/execute_multdiv_signfix.sv | 10 +
 rtl/execute_multdiv.sv | 164 ++++++++++++++++
 tb/tb_execute_multdiv.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/execute_multdiv_pkg.sv
// Shared constants for the iterative multiply/divide unit and the execute stage.
package execute_multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Exception codes the execute stage reports for a flagged mul/div result
  localparam logic [2:0] EXC_MUL = 3'd4;
  localparam logic [2:0] EXC_DIV = 3'd5;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/execute_multdiv_if.sv
// Request/response bundle between the execute stage and the mul/div unit.
interface execute_multdiv_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  logic             start;
  logic             is_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             stall;
  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] tag_out;
  logic             exception;

  modport master (
    output start, is_div, operand_a, operand_b, tag_in, flush,
    input  stall, result_valid, result, tag_out, exception
  );

  modport slave (
    input  start, is_div, operand_a, operand_b, tag_in, flush,
    output stall, result_valid, result, tag_out, exception
  );
endinterface

// File: rtl/execute_multdiv_signfix.sv
// Conditional two's-complement negation: operand magnitude on entry, sign restore on exit.
module multdiv_signfix #(
  parameter int unsigned N = 33
) (
  input  logic [N-1:0] x,
  input  logic         neg,
  output logic [N-1:0] y
);
  assign y = neg ? (~x + N'(1)) : x;
endmodule

// File: rtl/execute_multdiv.sv
// Iterative radix-2 signed multiply (shift-add) and restoring divide for the execute stage.
module execute_multdiv
  import execute_multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input logic               clock,
  input logic               reset,
  execute_multdiv_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH:0]     mag_b_q, mag_b_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [TAG_W-1:0]   tag_out_q, tag_out_d;
  logic               exc_q, exc_d;
  logic               valid_q, valid_d;

  logic [WIDTH:0]     mag_a_c, mag_b_c;
  logic [WIDTH:0]     mul_sum_c, div_shift_c, div_rem_c;
  logic               div_ge_c;
  logic [ACC_W-1:0]   step_c;
  logic [2*WIDTH-1:0] prod_s_c;
  logic [WIDTH-1:0]   quot_s_c;
  logic               mul_ovf_c, div_ovf_c;

  // Magnitudes in WIDTH+1 bits so INT_MIN is represented exactly
  multdiv_signfix #(.N(WIDTH + 1)) u_pre_a (
    .x   ({bus.operand_a[WIDTH-1], bus.operand_a}),
    .neg (bus.operand_a[WIDTH-1]),
    .y   (mag_a_c)
  );

  multdiv_signfix #(.N(WIDTH + 1)) u_pre_b (
    .x   ({bus.operand_b[WIDTH-1], bus.operand_b}),
    .neg (bus.operand_b[WIDTH-1]),
    .y   (mag_b_c)
  );

  // acc = {hi, lo}: mul keeps partial product in hi and multiplier in lo;
  // div keeps partial remainder in hi and shifts quotient bits into lo.
  always_comb begin
    mul_sum_c   = acc_q[ACC_W-1:WIDTH] + (acc_q[0] ? mag_b_q : '0);
    div_shift_c = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge_c    = (div_shift_c >= mag_b_q);
    div_rem_c   = div_ge_c ? (div_shift_c - mag_b_q) : div_shift_c;
    step_c      = is_div_q ? {div_rem_c, acc_q[WIDTH-2:0], div_ge_c}
                           : {1'b0, mul_sum_c, acc_q[WIDTH-1:1]};
  end

  multdiv_signfix #(.N(2 * WIDTH)) u_post_mul (
    .x   (step_c[2*WIDTH-1:0]),
    .neg (neg_q),
    .y   (prod_s_c)
  );

  multdiv_signfix #(.N(WIDTH)) u_post_div (
    .x   (step_c[WIDTH-1:0]),
    .neg (neg_q),
    .y   (quot_s_c)
  );

  // Product overflows unless the top WIDTH+1 bits are a pure sign extension
  assign mul_ovf_c = ~((&prod_s_c[2*WIDTH-1:WIDTH-1]) | ~(|prod_s_c[2*WIDTH-1:WIDTH-1]));
  // A positive quotient of magnitude 2^(WIDTH-1) only arises from INT_MIN / -1
  assign div_ovf_c = ~neg_q & step_c[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mag_b_d   = mag_b_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    tag_d     = tag_q;
    result_d  = result_q;
    tag_out_d = tag_out_q;
    exc_d     = exc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          is_div_d = bus.is_div;
          tag_d    = bus.tag_in;
          neg_d    = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
          mag_b_d  = mag_b_c;
          acc_d    = ACC_W'(mag_a_c);
          cnt_d    = '0;
          if (bus.is_div && (bus.operand_b == '0)) begin
            state_d   = ST_DONE;
            result_d  = '0;
            exc_d     = 1'b1;
            tag_out_d = bus.tag_in;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = step_c;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d   = ST_DONE;
            tag_out_d = tag_q;
            result_d  = is_div_q ? quot_s_c : prod_s_c[WIDTH-1:0];
            exc_d     = is_div_q ? div_ovf_c : mul_ovf_c;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_b_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      tag_q     <= '0;
      result_q  <= '0;
      tag_out_q <= '0;
      exc_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mag_b_q   <= mag_b_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      tag_q     <= tag_d;
      result_q  <= result_d;
      tag_out_q <= tag_out_d;
      exc_q     <= exc_d;
      valid_q   <= valid_d;
    end
  end

  // Stall follows the request combinationally so the issuing cycle is frozen too
  assign bus.stall        = ((state_q == ST_IDLE) && bus.start) || (state_q == ST_RUN);
  assign bus.result_valid = valid_q;
  assign bus.result       = result_q;
  assign bus.tag_out      = tag_out_q;
  assign bus.exception    = exc_q;

endmodule

// File: tb/tb_execute_multdiv.sv
// Directed scoreboard bench for execute_multdiv at WIDTH=32.
module tb_execute_multdiv;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;

  typedef struct packed {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    logic          exc;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sbq[$];

  always #5 clock = ~clock;

  execute_multdiv_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  execute_multdiv #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic void model(input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic e);
    longint sa, sb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!d) begin
      p = sa * sb;
      r = 32'(p);
      e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    end else if (b == '0) begin
      r = '0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = a;
      e = 1'b1;
    end else begin
      p = sa / sb;
      r = 32'(p);
      e = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op in cycle 0, optionally pulse a spurious start at cycle poke, check result
  task automatic run_op(input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] tag, input int lat, input int poke);
    exp_t e, got;
    int   c, stall_lo;
    bit   seen;
    model(d, a, b, e.res, e.exc);
    e.tag = tag;
    sbq.push_back(e);
    bus.start = 1'b1; bus.is_div = d; bus.operand_a = a; bus.operand_b = b; bus.tag_in = tag;
    @(negedge clock);
    check("stall_issue", bus.stall, 1);
    tick();
    bus.start = 1'b0;
    c = 1; stall_lo = 0; seen = 1'b0;
    while (c <= 100) begin
      if (c == poke) begin
        bus.start = 1'b1; bus.is_div = ~d; bus.operand_a = 32'h1234; bus.operand_b = 32'h3;
        bus.tag_in = ~tag;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clock);
      if (bus.result_valid) begin
        seen = 1'b1;
        break;
      end
      if (!bus.stall) stall_lo++;
      tick();
      c++;
    end
    bus.start = 1'b0;
    check("valid_seen", seen, 1);
    check("latency", c, lat);
    check("stall_busy", stall_lo, 0);
    check("stall_done", bus.stall, 0);
    if (sbq.size() > 0) begin
      got = sbq.pop_front();
      if (seen) begin
        check("result", bus.result, got.res);
        check("tag_out", bus.tag_out, got.tag);
        check("exception", bus.exception, got.exc);
      end
    end
    tick();
  endtask

  initial begin
    int  stall_hi;
    bit  seen;
    bus.start = 1'b0; bus.is_div = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
    bus.tag_in = '0; bus.flush = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_stall", bus.stall, 0);
    check("rst_valid", bus.result_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_tag", bus.tag_out, 0);
    check("rst_exc", bus.exception, 0);
    reset = 1'b1;
    tick();

    run_op(1'b0, 32'd6,          32'd7,          5'd3,  33, 0);
    run_op(1'b0, -32'sd7,        32'd3,          5'd9,  33, 0);
    run_op(1'b0, 32'h7FFF_FFFF,  32'd2,          5'd31, 33, 0);
    run_op(1'b1, 32'd100,        32'd7,          5'd1,  33, 0);
    run_op(1'b1, -32'sd100,      32'd7,          5'd2,  33, 5);
    run_op(1'b1, 32'd5,          32'd0,          5'd4,  1,  0);
    run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd5,  33, 0);
    run_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  5'd6,  33, 0);
    run_op(1'b1, 32'h8000_0000,  32'd1,          5'd8,  33, 0);
    run_op(1'b1, 32'd7,          -32'sd100,      5'd10, 33, 0);
    run_op(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd12, 33, 0);

    // Flush a multiply at cycle 10, restart at cycle 12
    bus.start = 1'b1; bus.is_div = 1'b0; bus.operand_a = 32'd99; bus.operand_b = 32'd5;
    bus.tag_in = 5'd20;
    tick();
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      bus.flush = (c == 10);
      @(negedge clock);
      if (bus.result_valid) seen = 1'b1;
      if (c == 10) check("stall_flush_cyc", bus.stall, 1);
      if (c == 11) check("stall_after_flush", bus.stall, 0);
      tick();
    end
    bus.flush = 1'b0;
    check("flush_no_valid", seen, 0);
    run_op(1'b0, 32'd12345, -32'sd678, 5'd11, 33, 0);

    // Asynchronous reset in the middle of a multiply
    bus.start = 1'b1; bus.is_div = 1'b0; bus.operand_a = 32'd1000; bus.operand_b = 32'd1000;
    bus.tag_in = 5'd7;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_stall", bus.stall, 0);
    check("mid_rst_valid", bus.result_valid, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_tag", bus.tag_out, 0);
    check("mid_rst_exc", bus.exception, 0);
    tick(); tick();
    reset = 1'b1;
    seen = 1'b0; stall_hi = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (bus.result_valid) seen = 1'b1;
      if (bus.stall) stall_hi++;
      tick();
    end
    check("post_rst_no_valid", seen, 0);
    check("post_rst_idle", stall_hi, 0);

    run_op(1'b0, -32'sd6, -32'sd7, 5'd17, 33, 0);
    check("scoreboard_empty", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
